// File: rtl/mem_responder_mc_if.sv
// Request/response bundle between a CPU-side requester and the memory responder.
// The master drives requests; the slave answers with ready and read strobes.
interface mem_responder_mc_if #(
  parameter int ADDR_W = 16
);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data_in;
  logic              ready;
  logic [15:0]       data_out;
  logic              data_valid;
  logic [ADDR_W-1:0] resp_addr;

  modport master (
    output enable, wr, addr, data_in,
    input  ready, data_out, data_valid, resp_addr
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output ready, data_out, data_valid, resp_addr
  );
endinterface

// File: rtl/mem_responder_mc.sv
// Fixed-latency 16-bit word memory with an in-order read response pipe.
// Optional single-outstanding mode holds ready low while a read is in flight.
module mem_responder_mc #(
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 15,
  parameter int LATENCY    = 4,
  parameter bit PIPELINED  = 1'b1
) (
  input logic clk,
  input logic rst,
  mem_responder_mc_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [LATENCY-1:0]    pv;
  logic [15:0]           pd [LATENCY];
  logic [ADDR_W-1:0]     pa [LATENCY];

  assign idx    = bus.addr[DEPTH_LOG2:1];
  assign bus.ready = !rst && (PIPELINED || state == IDLE);
  assign accept = bus.enable && bus.ready;
  assign rd_acc = accept && !bus.wr;
  assign wr_acc = accept && bus.wr;

  // No reset on the array: committed writes survive rst.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[idx] <= bus.data_in;
  end

  // Idle pipe slots carry zeros so outputs are 0 without a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pd[i] <= '0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= rd_acc;
      pd[0] <= rd_acc ? mem[idx] : '0;
      pa[0] <= rd_acc ? bus.addr : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (rd_acc && !PIPELINED) state <= BUSY;
        BUSY: if (pv[LATENCY-1]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_valid = pv[LATENCY-1];
  assign bus.data_out   = pd[LATENCY-1];
  assign bus.resp_addr  = pa[LATENCY-1];
endmodule

// File: tb/tb_mem_responder_mc.sv
// Scoreboard bench: u0 pipelined full-depth, u1 single-outstanding 16-word.
// Expected reads come from a word-indexed reference array kept here.
module tb_mem_responder_mc;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_mc_if #(.ADDR_W(16)) b0 ();
  mem_responder_mc_if #(.ADDR_W(16)) b1 ();

  mem_responder_mc #(
    .ADDR_W(16), .DEPTH_LOG2(15),
    .LATENCY(LAT), .PIPELINED(1'b1)
  ) u0 (.clk(clk), .rst(rst), .bus(b0));

  mem_responder_mc #(
    .ADDR_W(16), .DEPTH_LOG2(4),
    .LATENCY(LAT), .PIPELINED(1'b0)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic [15:0] data;
    logic [15:0] addr;
    int          edge_n;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] model [int];
  int          total = 0;
  int          bad   = 0;
  int          edges = 0;
  int          acc1, acc2;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int key(input int u, input logic [15:0] a);
    if (u == 0) return int'(a >> 1);
    return 65536 + int'((a >> 1) % 16);
  endfunction

  task automatic drive(input int u, input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    if (u == 0) begin
      b0.enable = en; b0.wr = w; b0.addr = a; b0.data_in = d;
    end else begin
      b1.enable = en; b1.wr = w; b1.addr = a; b1.data_in = d;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      drive(1, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clk);
    end
  endtask

  // Called at a falling edge; holds the request until it is accepted.
  task automatic req(input int u, input logic w, input logic [15:0] a,
                     input logic [15:0] d, output int acc);
    exp_t e;
    logic r;
    int   en;
    acc = -1;
    drive(u, 1'b1, w, a, d);
    for (int k = 0; k < 40; k++) begin
      r  = (u == 0) ? b0.ready : b1.ready;
      en = edges;
      @(posedge clk);
      if (r) begin
        acc = en + 1;
        if (w) begin
          model[key(u, a)] = d;
        end else begin
          e.data = model[key(u, a)];
          e.addr = a;
          e.edge_n = acc;
          if (u == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        @(negedge clk);
        drive(u, 1'b0, 1'b0, 16'h0, 16'h0);
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL u%0d_accept_timeout: addr %h never accepted", u, a);
    drive(u, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst) begin
      chk("u0_rst_ready", b0.ready, 0);
      chk("u0_rst_valid", b0.data_valid, 0);
    end else begin
      chk("u0_ready", b0.ready, 1);
      if (b0.data_valid) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL u0_spurious: strobe addr %h, none expected",
                   b0.resp_addr);
        end else begin
          e = q0.pop_front();
          chk("u0_data", b0.data_out, e.data);
          chk("u0_addr", b0.resp_addr, e.addr);
          chk("u0_latency", edges, e.edge_n + LAT - 1);
        end
      end else begin
        chk("u0_idle_data", b0.data_out, 0);
        chk("u0_idle_addr", b0.resp_addr, 0);
      end
    end
  end

  // u1 may only be ready when no read of it is still outstanding.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst) begin
      chk("u1_rst_ready", b1.ready, 0);
      chk("u1_rst_valid", b1.data_valid, 0);
    end else begin
      chk("u1_ready", b1.ready, (q1.size() == 0) ? 1 : 0);
      if (b1.data_valid) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL u1_spurious: strobe addr %h, none expected",
                   b1.resp_addr);
        end else begin
          e = q1.pop_front();
          chk("u1_data", b1.data_out, e.data);
          chk("u1_addr", b1.resp_addr, e.addr);
          chk("u1_latency", edges, e.edge_n + LAT - 1);
        end
      end else begin
        chk("u1_idle_data", b1.data_out, 0);
        chk("u1_idle_addr", b1.resp_addr, 0);
      end
    end
  end

  initial begin
    int acc;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("reset_ready0", b0.ready, 0);
    chk("reset_valid0", b0.data_valid, 0);
    chk("reset_ready1", b1.ready, 0);
    chk("reset_dout1", b1.data_out, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 64; i++)
      req(0, 1'b1, 16'(2 * i), 16'($urandom), acc);
    for (int i = 0; i < 16; i++)
      req(1, 1'b1, 16'(2 * i), 16'($urandom), acc);

    req(0, 1'b1, 16'h0010, 16'hBEEF, acc);
    req(0, 1'b0, 16'h0010, 16'h0, acc);
    req(0, 1'b0, 16'h0000, 16'h0, acc);
    req(0, 1'b0, 16'h0002, 16'h0, acc);
    req(0, 1'b0, 16'h0004, 16'h0, acc);
    req(0, 1'b1, 16'h0007, 16'h1234, acc);
    req(0, 1'b0, 16'h0006, 16'h0, acc);
    req(0, 1'b1, 16'hFFFF, 16'hA5C3, acc);
    req(0, 1'b0, 16'hFFFE, 16'h0, acc);
    req(0, 1'b0, 16'hFFFF, 16'h0, acc);
    drain();

    for (int i = 0; i < 150; i++) begin
      req(0, 1'($urandom), 16'($urandom_range(0, 127)),
          16'($urandom), acc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    req(1, 1'b0, 16'h0020, 16'h0, acc1);
    req(1, 1'b0, 16'h0022, 16'h0, acc2);
    chk("u1_hold_gap", acc2 - acc1, LAT + 1);
    req(1, 1'b1, 16'h0007, 16'h1234, acc);
    req(1, 1'b0, 16'h0006, 16'h0, acc);
    req(1, 1'b0, 16'h0026, 16'h0, acc);
    drain();

    for (int i = 0; i < 60; i++) begin
      req(1, 1'($urandom), 16'($urandom), 16'($urandom), acc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();

    req(0, 1'b1, 16'h0010, 16'hBEEF, acc);
    req(0, 1'b0, 16'h0010, 16'h0, acc);
    req(0, 1'b0, 16'h0002, 16'h0, acc);
    idle(1);
    #2 rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("rst_mid_valid", b0.data_valid, 0);
    chk("rst_mid_dout", b0.data_out, 0);
    chk("rst_mid_raddr", b0.resp_addr, 0);
    chk("rst_mid_ready", b0.ready, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    idle(8);
    req(0, 1'b0, 16'h0010, 16'h0, acc);
    req(1, 1'b0, 16'h0026, 16'h0, acc);
    drain();

    idle(20);
    for (int i = 0; i < 16; i++) begin
      req(0, 1'b0, 16'(2 * i), 16'h0, acc);
      req(1, 1'b0, 16'(2 * i), 16'h0, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
